// File: rtl/lpc_sync_ring_fifo_pkg.sv
// Shared LPC capture-path sizing used by the frame decoder, this FIFO and the UART framer.
// Defaults size the on-chip capture buffer; the framer relies on the same word width.
package lpc_sync_ring_fifo_pkg;

   localparam int LPC_FIFO_WIDTH     = 8;
   localparam int LPC_FIFO_ADDR_BITS = 5;
   localparam int LPC_DROP_BITS      = 8;

endpackage

// File: rtl/lpc_ring_mem.sv
// DEPTH x WIDTH ring storage: synchronous write, asynchronous read (read latency 0).
// No flow control here; the owner gates i_wr_en. Kept separate so a BRAM wrapper can drop in.
module lpc_ring_mem #(
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 5
) (
   input  logic                 i_clk,
   input  logic                 i_wr_en,
   input  logic [ADDR_BITS-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]     i_wr_data,
   input  logic [ADDR_BITS-1:0] i_rd_addr,
   output logic [WIDTH-1:0]     o_rd_data
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lpc_sync_ring_fifo.sv
// Single-clock FWFT ring FIFO for LPC capture; write-to-rd_valid latency 1 cycle, all DEPTH slots used.
// Writes while full are dropped (sticky overflow + saturating drop_count); reads gated by rd_ready.
module lpc_sync_ring_fifo
   import lpc_sync_ring_fifo_pkg::*;
#(
   parameter int WIDTH     = LPC_FIFO_WIDTH,
   parameter int ADDR_BITS = LPC_FIFO_ADDR_BITS,
   parameter int AF_THRESH = (1 << ADDR_BITS) - 4,
   parameter int DROP_BITS = LPC_DROP_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 rd_ready,
   output logic                 rd_valid,
   output logic [WIDTH-1:0]     rd_data,
   output logic [ADDR_BITS:0]   count,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow,
   input  logic                 clr_ovf,
   output logic [DROP_BITS-1:0] drop_count
);

   localparam logic [ADDR_BITS:0]   C_DEPTH    = (ADDR_BITS + 1)'(1 << ADDR_BITS);
   localparam logic [ADDR_BITS:0]   C_AF       = (ADDR_BITS + 1)'(AF_THRESH);
   localparam logic [DROP_BITS-1:0] C_DROP_MAX = '1;

   logic [ADDR_BITS-1:0] r_wr_ptr;
   logic [ADDR_BITS-1:0] r_rd_ptr;
   logic [ADDR_BITS:0]   r_count;
   logic                 r_overflow;
   logic [DROP_BITS-1:0] r_drop_count;

   logic                 w_wr_acc;
   logic                 w_wr_drop;
   logic                 w_rd_acc;
   logic [ADDR_BITS:0]   w_count_nxt;

   // Flags come only from registered count, so full/empty never see same-cycle reads.
   assign empty       = (r_count == '0);
   assign full        = (r_count == C_DEPTH);
   assign almost_full = (r_count >= C_AF);
   assign rd_valid    = !empty;
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign drop_count  = r_drop_count;

   // A write lost to flush is not a drop.
   assign w_wr_acc  = wr_en && !full && !flush;
   assign w_wr_drop = wr_en &&  full && !flush;
   assign w_rd_acc  = rd_ready && rd_valid && !flush;

   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // clr_ovf beats a simultaneous drop; flush clears overflow but keeps drop history.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (clr_ovf || flush) begin
            r_overflow <= 1'b0;
         end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
         end

         if (clr_ovf) begin
            r_drop_count <= '0;
         end else if (w_wr_drop && (r_drop_count != C_DROP_MAX)) begin
            r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   lpc_ring_mem #(
      .WIDTH     (WIDTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .i_clk     (clock),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (rd_data)
   );

endmodule

// File: tb/tb_lpc_sync_ring_fifo.sv
// Scoreboarded bench for lpc_sync_ring_fifo at DEPTH=4, AF_THRESH=3, DROP_BITS=2.
module tb_lpc_sync_ring_fifo;

   localparam int WIDTH     = 8;
   localparam int ADDR_BITS = 2;
   localparam int AF_THRESH = 3;
   localparam int DROP_BITS = 2;

   logic                 clock;
   logic                 reset;
   logic                 flush;
   logic                 wr_en;
   logic [WIDTH-1:0]     wr_data;
   logic                 rd_ready;
   logic                 rd_valid;
   logic [WIDTH-1:0]     rd_data;
   logic [ADDR_BITS:0]   count;
   logic                 empty;
   logic                 full;
   logic                 almost_full;
   logic                 overflow;
   logic                 clr_ovf;
   logic [DROP_BITS-1:0] drop_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   lpc_sync_ring_fifo #(
      .WIDTH     (WIDTH),
      .ADDR_BITS (ADDR_BITS),
      .AF_THRESH (AF_THRESH),
      .DROP_BITS (DROP_BITS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_ready    (rd_ready),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf),
      .drop_count  (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: every accepted read must match the oldest expected word.
   always @(negedge clock) begin
      if (reset && rd_valid && rd_ready && !flush) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_unexpected got=%02h expected none", rd_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               n_errors++;
               $display("FAIL rd_data got=%02h exp=%02h", rd_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic we, input logic [WIDTH-1:0] wd, input logic rr,
                      input logic fl, input logic co);
      wr_en    = we;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      clr_ovf  = co;
      @(posedge clock);
      #1;
      wr_en    = 1'b0;
      rd_ready = 1'b0;
      flush    = 1'b0;
      clr_ovf  = 1'b0;
   endtask

   task automatic wr_push(input logic [WIDTH-1:0] d);
      exp_q.push_back(d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr_drop(input logic [WIDTH-1:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"},    int'(count), 0);
      chk({tag, "_empty"},    int'(empty), 1);
      chk({tag, "_rd_valid"}, int'(rd_valid), 0);
      chk({tag, "_full"},     int'(full), 0);
      chk({tag, "_af"},       int'(almost_full), 0);
      chk({tag, "_ovf"},      int'(overflow), 0);
      chk({tag, "_drop"},     int'(drop_count), 0);
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
      rd_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;
      @(posedge clock); #1;

      // 1: fill, drop one, drain in order
      wr_push(8'h11); wr_push(8'h22); wr_push(8'h33); wr_push(8'h44);
      chk("t1_count", int'(count), 4);
      chk("t1_full", int'(full), 1);
      wr_drop(8'h55);
      chk("t1_ovf", int'(overflow), 1);
      chk("t1_drop", int'(drop_count), 1);
      chk("t1_count_after_drop", int'(count), 4);
      repeat (4) rd();
      chk("t1_empty", int'(empty), 1);
      chk("t1_ovf_sticky", int'(overflow), 1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t1_ovf_clr", int'(overflow), 0);

      // 2: alternate write/read, pointers wrap
      for (int i = 0; i < 10; i++) begin
         wr_push(8'hA0 + 8'(i));
         chk("t2_count_w", int'(count), 1);
         rd();
         chk("t2_count_r", int'(count), 0);
      end

      // 3: simultaneous read+write at count=2, then at empty
      wr_push(8'h31); wr_push(8'h32);
      exp_q.push_back(8'h33);
      cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      chk("t3_count_rw", int'(count), 2);
      rd(); rd();
      chk("t3_empty", int'(empty), 1);
      exp_q.push_back(8'h3C);
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      chk("t3_count_empty_rw", int'(count), 1);
      chk("t3_rd_valid", int'(rd_valid), 1);
      chk("t3_rd_data", int'(rd_data), 8'h3C);
      rd();

      // 4: almost_full threshold
      wr_push(8'h41); wr_push(8'h42);
      chk("t4_af_2", int'(almost_full), 0);
      wr_push(8'h43);
      chk("t4_af_3", int'(almost_full), 1);
      rd();
      chk("t4_af_after_rd", int'(almost_full), 0);
      chk("t4_count", int'(count), 2);
      rd(); rd();

      // 5: drop counter saturation, clear, clear racing a drop
      wr_push(8'h51); wr_push(8'h52); wr_push(8'h53); wr_push(8'h54);
      for (int i = 0; i < 5; i++) wr_drop(8'h5F);
      chk("t5_drop_sat", int'(drop_count), 3);
      chk("t5_ovf", int'(overflow), 1);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t5_ovf_clr", int'(overflow), 0);
      chk("t5_drop_clr", int'(drop_count), 0);
      cyc(1'b1, 8'h5E, 1'b0, 1'b0, 1'b1);
      chk("t5_clr_wins_ovf", int'(overflow), 0);
      chk("t5_clr_wins_drop", int'(drop_count), 0);
      repeat (4) rd();

      // 6: flush with a concurrent write; drop_count survives flush
      wr_push(8'h61); wr_push(8'h62); wr_push(8'h63); wr_push(8'h64);
      wr_drop(8'h6F);
      exp_q.delete();
      cyc(1'b1, 8'h70, 1'b0, 1'b1, 1'b0);
      chk("t6_count", int'(count), 0);
      chk("t6_empty", int'(empty), 1);
      chk("t6_ovf", int'(overflow), 0);
      chk("t6_drop_kept", int'(drop_count), 1);
      wr_push(8'h65);
      chk("t6_rd_data_post_flush", int'(rd_data), 8'h65);
      rd();

      // Async reset mid-cycle with data, overflow and drops pending
      wr_push(8'h71); wr_push(8'h72); wr_push(8'h73); wr_push(8'h74);
      wr_drop(8'h7F);
      chk("t7_drop_pre", int'(drop_count), 2);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("t7");
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      wr_push(8'h81);
      chk("t7_count_after", int'(count), 1);
      rd();

      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
